closeloop_seq: RTL and testbench

CLOSELOOP_SEQ -- requirements
Module: closeloop_seq

---
 rtl/closeloop_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_closeloop_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/closeloop_seq.sv
// Closed-loop acquisition sequencer: settle, coarse/fine acquisition, lock tracking with
// relock retries, and a windowed rate accumulator of feedback steps while locked.
module closeloop_seq #(
  parameter int unsigned ACC_LOG2  = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic               DAC_CLK,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_err_done,
  input  logic signed [31:0] i_err,
  input  logic signed [31:0] i_step,
  input  logic        [31:0] i_settle_cnt,
  input  logic        [31:0] i_lock_th,
  input  logic        [15:0] i_lock_n,
  input  logic        [15:0] i_unlock_n,
  input  logic        [3:0]  i_gain_coarse,
  input  logic        [3:0]  i_gain_fine,
  output logic        [3:0]  o_gain_sel,
  output logic               o_fb_en,
  output logic        [2:0]  o_state,
  output logic               o_locked,
  output logic        [1:0]  o_retry,
  output logic signed [31:0] o_rate_acc,
  output logic               o_rate_valid
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StCoarse = 3'd2,
    StFine   = 3'd3,
    StLock   = 3'd4,
    StFault  = 3'd5
  } state_e;

  localparam int unsigned CntW = ACC_LOG2 + 1;
  localparam logic [CntW-1:0] WinLast = CntW'((2 ** ACC_LOG2) - 1);

  state_e         state_q, state_d;
  logic [31:0]    settle_q, settle_d;
  logic [15:0]    run_q, run_d;
  logic [15:0]    miss_q, miss_d;
  logic [1:0]     retry_q, retry_d;
  logic [31:0]    acc_q, acc_d;
  logic [CntW-1:0] win_cnt_q, win_cnt_d;
  logic [31:0]    rate_acc_q, rate_acc_d;
  logic           rate_valid_q, rate_valid_d;
  logic           fb_en_q, fb_en_d;
  logic [3:0]     gain_q, gain_d;
  logic           locked_q, locked_d;

  logic [31:0] err_raw;
  logic [31:0] err_mag;
  logic        in_th;
  logic [15:0] lock_need;
  logic [15:0] unlock_need;
  logic        run_hit;
  logic        miss_hit;
  logic        retry_left;
  logic [31:0] acc_sum;
  logic        accumulate;

  // Magnitude saturates so that -2^31 maps onto the largest positive value.
  assign err_raw = i_err;
  always_comb begin
    if (!err_raw[31]) begin
      err_mag = err_raw;
    end else if (err_raw == 32'h8000_0000) begin
      err_mag = 32'h7FFF_FFFF;
    end else begin
      err_mag = ~err_raw + 32'd1;
    end
  end

  assign in_th       = (err_mag <= i_lock_th);
  assign lock_need   = (i_lock_n == 16'd0) ? 16'd1 : i_lock_n;
  assign unlock_need = (i_unlock_n == 16'd0) ? 16'd1 : i_unlock_n;
  assign run_hit     = ((run_q + 16'd1) >= lock_need);
  assign miss_hit    = ((miss_q + 16'd1) >= unlock_need);
  assign retry_left  = (32'(retry_q) < MAX_RETRY);
  assign acc_sum     = acc_q + i_step;

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    run_d        = run_q;
    miss_d       = miss_q;
    retry_d      = retry_q;
    acc_d        = acc_q;
    win_cnt_d    = win_cnt_q;
    rate_acc_d   = rate_acc_q;
    rate_valid_d = 1'b0;
    accumulate   = 1'b0;

    case (state_q)
      StIdle: begin
        run_d  = '0;
        miss_d = '0;
        if (i_start) begin
          state_d  = StSettle;
          settle_d = i_settle_cnt;
          retry_d  = '0;
        end
      end
      // A load of N gives N clocks here, and a load of 0 still gives one.
      StSettle: begin
        if (settle_q <= 32'd1) begin
          state_d  = StCoarse;
          settle_d = '0;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      StCoarse, StFine: begin
        if (i_err_done) begin
          if (!in_th) begin
            run_d = '0;
          end else if (run_hit) begin
            run_d   = '0;
            state_d = (state_q == StCoarse) ? StFine : StLock;
          end else begin
            run_d = run_q + 16'd1;
          end
        end
      end
      StLock: begin
        if (i_err_done) begin
          if (in_th) begin
            miss_d     = '0;
            accumulate = 1'b1;
          end else if (miss_hit) begin
            miss_d = '0;
            run_d  = '0;
            if (retry_left) begin
              state_d = StCoarse;
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = StFault;
            end
          end else begin
            miss_d     = miss_q + 16'd1;
            accumulate = 1'b1;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accumulate) begin
      if (win_cnt_q == WinLast) begin
        rate_acc_d   = acc_sum;
        rate_valid_d = 1'b1;
        acc_d        = '0;
        win_cnt_d    = '0;
      end else begin
        acc_d     = acc_sum;
        win_cnt_d = win_cnt_q + CntW'(1);
      end
    end

    // Any exit from LOCK drops the partial window.
    if (state_d != StLock) begin
      acc_d     = '0;
      win_cnt_d = '0;
    end

    if (!i_start) begin
      state_d      = StIdle;
      settle_d     = '0;
      run_d        = '0;
      miss_d       = '0;
      retry_d      = '0;
      acc_d        = '0;
      win_cnt_d    = '0;
      rate_acc_d   = rate_acc_q;
      rate_valid_d = 1'b0;
    end
  end

  // State outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    fb_en_d  = (state_d == StCoarse) || (state_d == StFine) || (state_d == StLock);
    gain_d   = ((state_d == StFine) || (state_d == StLock)) ? i_gain_fine : i_gain_coarse;
    locked_d = (state_d == StLock);
  end

  always_ff @(posedge DAC_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      settle_q     <= '0;
      run_q        <= '0;
      miss_q       <= '0;
      retry_q      <= '0;
      acc_q        <= '0;
      win_cnt_q    <= '0;
      rate_acc_q   <= '0;
      rate_valid_q <= 1'b0;
      fb_en_q      <= 1'b0;
      gain_q       <= '0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      retry_q      <= retry_d;
      acc_q        <= acc_d;
      win_cnt_q    <= win_cnt_d;
      rate_acc_q   <= rate_acc_d;
      rate_valid_q <= rate_valid_d;
      fb_en_q      <= fb_en_d;
      gain_q       <= gain_d;
      locked_q     <= locked_d;
    end
  end

  assign o_state      = state_q;
  assign o_fb_en      = fb_en_q;
  assign o_gain_sel   = gain_q;
  assign o_locked     = locked_q;
  assign o_retry      = retry_q;
  assign o_rate_acc   = rate_acc_q;
  assign o_rate_valid = rate_valid_q;

endmodule

// File: tb/tb_closeloop_seq.sv
// Scoreboard bench for closeloop_seq: stimulus queues expected state transitions and rate
// windows; a negedge monitor pops and compares whenever the DUT changes state or strobes a rate.
module tb_closeloop_seq;

  localparam logic [2:0] SIdle = 3'd0, SSettle = 3'd1, SCoarse = 3'd2;
  localparam logic [2:0] SFine = 3'd3, SLock = 3'd4, SFault = 3'd5;
  localparam logic [3:0] GC = 4'h3, GF = 4'hA;

  logic               DAC_CLK = 1'b0;
  logic               rst_n = 1'b1;
  logic               i_start, i_err_done;
  logic signed [31:0] i_err, i_step;
  logic        [31:0] i_settle_cnt, i_lock_th;
  logic        [15:0] i_lock_n, i_unlock_n;
  logic        [3:0]  i_gain_coarse, i_gain_fine;
  logic        [3:0]  o_gain_sel;
  logic               o_fb_en, o_locked, o_rate_valid;
  logic        [2:0]  o_state;
  logic        [1:0]  o_retry;
  logic signed [31:0] o_rate_acc;

  closeloop_seq #(
    .ACC_LOG2  (2),
    .MAX_RETRY (3)
  ) dut (
    .DAC_CLK       (DAC_CLK),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_err_done    (i_err_done),
    .i_err         (i_err),
    .i_step        (i_step),
    .i_settle_cnt  (i_settle_cnt),
    .i_lock_th     (i_lock_th),
    .i_lock_n      (i_lock_n),
    .i_unlock_n    (i_unlock_n),
    .i_gain_coarse (i_gain_coarse),
    .i_gain_fine   (i_gain_fine),
    .o_gain_sel    (o_gain_sel),
    .o_fb_en       (o_fb_en),
    .o_state       (o_state),
    .o_locked      (o_locked),
    .o_retry       (o_retry),
    .o_rate_acc    (o_rate_acc),
    .o_rate_valid  (o_rate_valid)
  );

  always #5 DAC_CLK = ~DAC_CLK;

  typedef struct {
    logic [2:0] st;
    logic       fb;
    logic [3:0] gain;
    logic       lk;
    logic [1:0] retry;
    int         strobes;  // strobe count at entry, -1 = don't care
    int         dwell;    // clocks spent in the previous state, -1 = don't care
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rate_q[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;

  task automatic tick();
    @(posedge DAC_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic fb, input logic [3:0] gain,
                      input logic lk, input logic [1:0] retry, input int strb, input int dwell);
    exp_t e;
    e.st = st; e.fb = fb; e.gain = gain; e.lk = lk; e.retry = retry;
    e.strobes = strb; e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  // One error sample, then three idle clocks: a strobe every 4th clock.
  task automatic strobe(input logic [31:0] err, input logic [31:0] step);
    i_err      = err;
    i_step     = step;
    i_err_done = 1'b1;
    strobes++;
    tick();
    i_err_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit);
    int n;
    n = 0;
    while (o_state !== st && n < limit) begin
      tick();
      n++;
    end
    check("wait_state", {61'd0, o_state}, {61'd0, st});
  endtask

  // Monitor
  initial begin : monitor
    logic [2:0] prev_st;
    int         run_len;
    exp_t       e;
    logic [31:0] r;
    prev_st = 3'd0;
    run_len = 0;
    forever begin
      @(negedge DAC_CLK);
      if (o_state !== prev_st) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: got state %0d from %0d expected none",
                   o_state, prev_st);
        end else begin
          e = exp_q.pop_front();
          if (o_state !== e.st || o_fb_en !== e.fb || o_gain_sel !== e.gain ||
              o_locked !== e.lk || o_retry !== e.retry ||
              (e.strobes >= 0 && strobes != e.strobes) || (e.dwell >= 0 && run_len != e.dwell)) begin
            errors++;
            $display("FAIL transition: got st=%0d fb=%0b gain=%0h lk=%0b retry=%0d strobes=%0d dwell=%0d expected st=%0d fb=%0b gain=%0h lk=%0b retry=%0d strobes=%0d dwell=%0d",
                     o_state, o_fb_en, o_gain_sel, o_locked, o_retry, strobes, run_len,
                     e.st, e.fb, e.gain, e.lk, e.retry, e.strobes, e.dwell);
          end
        end
        prev_st = o_state;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (o_rate_valid === 1'b1) begin
        checks++;
        if (rate_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rate: got %0d expected no o_rate_valid", o_rate_acc);
        end else begin
          r = rate_q.pop_front();
          if (o_rate_acc !== r) begin
            errors++;
            $display("FAIL rate_acc: got %0d expected %0d", o_rate_acc, $signed(r));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0;
    i_start = 1'b0; i_err_done = 1'b0; i_err = '0; i_step = '0;
    i_settle_cnt = 32'd5; i_lock_th = 32'd100; i_lock_n = 16'd3; i_unlock_n = 16'd2;
    i_gain_coarse = GC; i_gain_fine = GF;
    repeat (2) tick();
    check("reset_outputs", {52'd0, o_state, o_fb_en, o_gain_sel, o_locked, o_retry, o_rate_valid},
          64'd0);
    check("reset_rate_acc", {32'd0, o_rate_acc}, 64'd0);

    // Release with start high, settle 5, acquisition with lock_n=3
    i_start = 1'b1;
    push(SSettle, 1'b0, GC, 1'b0, 2'd0, -1, -1);
    push(SCoarse, 1'b1, GC, 1'b0, 2'd0, -1, 5);
    rst_n = 1'b1;
    tick();
    check("settle_first_clock", {61'd0, o_state}, {61'd0, SSettle});
    wait_state(SCoarse, 20);
    strobes = 0;
    push(SFine, 1'b1, GF, 1'b0, 2'd0, 3, -1);
    push(SLock, 1'b1, GF, 1'b1, 2'd0, 6, -1);
    repeat (6) strobe(32'd0, 32'd1000);
    check("locked_level", {63'd0, o_locked}, 64'd1);

    // Two full rate windows of 4 samples
    rate_q.push_back(32'd15);
    strobe(32'd0, 32'd10); strobe(32'd0, -32'sd3); strobe(32'd0, 32'd7); strobe(32'd0, 32'd1);
    rate_q.push_back(32'd10);
    strobe(32'd0, 32'd1); strobe(32'd0, 32'd2); strobe(32'd0, 32'd3); strobe(32'd0, 32'd4);

    // Partial window of 3; the unlocking 4th sample must not complete it
    push(SCoarse, 1'b1, GC, 1'b0, 2'd1, -1, -1);
    strobe(32'd0, 32'd5); strobe(32'd0, 32'd5); strobe(32'd1000, 32'd9); strobe(32'd1000, 32'd9);
    check("rate_acc_hold", {32'd0, o_rate_acc}, 64'd10);

    // lock_n=0 acts as 1; most-negative error is in-threshold at max threshold
    i_lock_n = 16'd0;
    i_lock_th = 32'h7FFF_FFFF;
    push(SFine, 1'b1, GF, 1'b0, 2'd1, -1, -1);
    strobe(32'h8000_0000, 32'd0);
    i_lock_th = 32'd100;
    push(SLock, 1'b1, GF, 1'b1, 2'd1, -1, -1);
    strobe(32'hFFFF_FFFB, 32'd1000);
    rate_q.push_back(32'd4);
    repeat (4) strobe(32'd0, 32'd1);

    // An in-threshold sample between misses resets the miss run
    strobes = 0;
    push(SCoarse, 1'b1, GC, 1'b0, 2'd2, 4, -1);
    strobe(32'd1000, 32'd0); strobe(32'd0, 32'd0);
    strobe(-32'sd1000, 32'd0); strobe(32'd1000, 32'd0);

    push(SFine, 1'b1, GF, 1'b0, 2'd2, -1, -1);
    strobe(32'd0, 32'd0);
    push(SLock, 1'b1, GF, 1'b1, 2'd2, -1, -1);
    strobe(32'd0, 32'd0);
    push(SCoarse, 1'b1, GC, 1'b0, 2'd3, -1, -1);
    strobe(32'd1000, 32'd0); strobe(32'd1000, 32'd0);

    push(SFine, 1'b1, GF, 1'b0, 2'd3, -1, -1);
    strobe(32'd0, 32'd0);
    push(SLock, 1'b1, GF, 1'b1, 2'd3, -1, -1);
    strobe(32'd0, 32'd0);
    push(SFault, 1'b0, GC, 1'b0, 2'd3, -1, -1);
    strobe(32'd1000, 32'd0); strobe(32'd1000, 32'd0);
    repeat (3) strobe(32'd0, 32'd0);
    check("fault_hold", {61'd0, o_state}, {61'd0, SFault});

    push(SIdle, 1'b0, GC, 1'b0, 2'd0, -1, -1);
    i_start = 1'b0;
    repeat (2) tick();

    // settle_cnt=0 gives exactly one clock in SETTLE; then in,in,out,in,in,in with lock_n=3
    i_settle_cnt = 32'd0;
    i_lock_n = 16'd3;
    push(SSettle, 1'b0, GC, 1'b0, 2'd0, -1, -1);
    push(SCoarse, 1'b1, GC, 1'b0, 2'd0, -1, 1);
    i_start = 1'b1;
    repeat (3) tick();
    strobes = 0;
    push(SFine, 1'b1, GF, 1'b0, 2'd0, 6, -1);
    strobe(32'd0, 32'd0); strobe(32'd50, 32'd0); strobe(32'd101, 32'd0);
    strobe(32'd100, 32'd0); strobe(-32'sd100, 32'd0); strobe(32'd0, 32'd0);

    // Start dropped on the strobe that would have entered LOCK
    strobe(32'd0, 32'd0); strobe(32'd0, 32'd0);
    push(SIdle, 1'b0, GC, 1'b0, 2'd0, -1, -1);
    i_err = '0; i_err_done = 1'b1; i_start = 1'b0;
    tick();
    i_err_done = 1'b0;
    tick();
    check("abort_idle", {61'd0, o_state}, {61'd0, SIdle});

    // Asynchronous reset in the middle of a rate window
    i_lock_n = 16'd1;
    push(SSettle, 1'b0, GC, 1'b0, 2'd0, -1, -1);
    push(SCoarse, 1'b1, GC, 1'b0, 2'd0, -1, 1);
    push(SFine, 1'b1, GF, 1'b0, 2'd0, -1, -1);
    push(SLock, 1'b1, GF, 1'b1, 2'd0, -1, -1);
    i_start = 1'b1;
    repeat (3) tick();
    strobe(32'd0, 32'd0); strobe(32'd0, 32'd0);
    strobe(32'd0, 32'd50); strobe(32'd0, 32'd50);
    push(SIdle, 1'b0, 4'h0, 1'b0, 2'd0, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {52'd0, o_state, o_fb_en, o_gain_sel, o_locked, o_retry, o_rate_valid}, 64'd0);
    check("async_reset_rate_acc", {32'd0, o_rate_acc}, 64'd0);
    repeat (2) tick();
    i_start = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();

    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("rate_queue_drained", 64'(rate_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
